// File: rtl/dp_instr_encoder.sv
// dp_instr_encoder: assembles ARM7TDMI data-processing instruction words from
// separate fields. In immediate mode it scans the 16 rotations, one per cycle,
// for an 8-bit immediate plus 4-bit rotate encoding. Holds one instruction in flight.
module dp_instr_encoder #(
    parameter bit FORCE_CANON = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  cond,
    input  logic [3:0]  opcode,
    input  logic        s_bit,
    input  logic [3:0]  rn,
    input  logic [3:0]  rd,
    input  logic        imm_mode,
    input  logic [31:0] imm_value,
    input  logic [7:0]  shift,
    input  logic [3:0]  rm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instruction,
    output logic        enc_error
);

    localparam int unsigned W_INSTR = 32;
    localparam int unsigned W_ROT   = 4;
    localparam int unsigned W_REG   = 4;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SEARCH = 2'd1;
    localparam logic [1:0] S_OUT    = 2'd2;

    logic [1:0]         state_q, state_n;
    logic [W_ROT-1:0]   rot_q, rot_n;
    logic [3:0]         cond_q, cond_n;
    logic [3:0]         opcode_q, opcode_n;
    logic               s_q, s_n;
    logic [W_REG-1:0]   rn_q, rn_n;
    logic [W_REG-1:0]   rd_q, rd_n;
    logic [31:0]        imm_q, imm_n;
    logic               in_ready_q, in_ready_n;
    logic               out_valid_q, out_valid_n;
    logic [W_INSTR-1:0] instr_q, instr_n;
    logic               err_q, err_n;

    logic               is_cmp_c;
    logic               is_mov_c;
    logic               s_canon_c;
    logic [W_REG-1:0]   rn_canon_c;
    logic [W_REG-1:0]   rd_canon_c;
    logic [63:0]        rot_wide_c;
    logic [31:0]        rot_val_c;
    logic               hit_c;

    // Canonicalise incoming fields: compares always set flags and have no Rd,
    // MOV/MVN have no Rn.
    always_comb begin
        is_cmp_c   = FORCE_CANON && (opcode[3:2] == 2'b10);
        is_mov_c   = FORCE_CANON && opcode[3] && opcode[2] && opcode[0];
        s_canon_c  = is_cmp_c ? 1'b1 : s_bit;
        rd_canon_c = is_cmp_c ? 4'd0 : rd;
        rn_canon_c = is_mov_c ? 4'd0 : rn;
    end

    // Rotate-left of the captured constant by 2*rot; a hit needs bits [31:8] clear.
    always_comb begin
        rot_wide_c = {imm_q, imm_q} << {rot_q, 1'b0};
        rot_val_c  = rot_wide_c[63:32];
        hit_c      = (rot_val_c[31:8] == 24'd0);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_n     = state_q;
        rot_n       = rot_q;
        cond_n      = cond_q;
        opcode_n    = opcode_q;
        s_n         = s_q;
        rn_n        = rn_q;
        rd_n        = rd_q;
        imm_n       = imm_q;
        in_ready_n  = in_ready_q;
        out_valid_n = out_valid_q;
        instr_n     = instr_q;
        err_n       = err_q;

        case (state_q)
            S_IDLE: begin
                in_ready_n  = 1'b1;
                out_valid_n = 1'b0;
                if (in_valid && in_ready_q) begin
                    cond_n     = cond;
                    opcode_n   = opcode;
                    s_n        = s_canon_c;
                    rn_n       = rn_canon_c;
                    rd_n       = rd_canon_c;
                    imm_n      = imm_value;
                    rot_n      = '0;
                    in_ready_n = 1'b0;
                    if (imm_mode) begin
                        state_n = S_SEARCH;
                    end else begin
                        state_n     = S_OUT;
                        out_valid_n = 1'b1;
                        err_n       = 1'b0;
                        instr_n     = {cond, 2'b00, 1'b0, opcode, s_canon_c,
                                       rn_canon_c, rd_canon_c, shift, rm};
                    end
                end
            end
            S_SEARCH: begin
                in_ready_n = 1'b0;
                if (hit_c) begin
                    state_n     = S_OUT;
                    out_valid_n = 1'b1;
                    err_n       = 1'b0;
                    instr_n     = {cond_q, 2'b00, 1'b1, opcode_q, s_q,
                                   rn_q, rd_q, rot_q, rot_val_c[7:0]};
                end else if (rot_q == 4'd15) begin
                    state_n     = S_OUT;
                    out_valid_n = 1'b1;
                    err_n       = 1'b1;
                    instr_n     = '0;
                end else begin
                    rot_n = rot_q + 4'd1;
                end
            end
            S_OUT: begin
                in_ready_n  = 1'b0;
                out_valid_n = 1'b1;
                if (out_ready) begin
                    state_n     = S_IDLE;
                    out_valid_n = 1'b0;
                    in_ready_n  = 1'b1;
                    rot_n       = '0;
                end
            end
            default: begin
                state_n     = S_IDLE;
                in_ready_n  = 1'b1;
                out_valid_n = 1'b0;
                rot_n       = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rot_q       <= '0;
            cond_q      <= '0;
            opcode_q    <= '0;
            s_q         <= 1'b0;
            rn_q        <= '0;
            rd_q        <= '0;
            imm_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            instr_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_n;
            rot_q       <= rot_n;
            cond_q      <= cond_n;
            opcode_q    <= opcode_n;
            s_q         <= s_n;
            rn_q        <= rn_n;
            rd_q        <= rd_n;
            imm_q       <= imm_n;
            in_ready_q  <= in_ready_n;
            out_valid_q <= out_valid_n;
            instr_q     <= instr_n;
            err_q       <= err_n;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign instruction = instr_q;
    assign enc_error   = err_q;

endmodule

// File: tb/tb_dp_instr_encoder.sv
// Testbench for dp_instr_encoder: table of field sets with hand-derived
// instruction words and latencies, a scoreboard queue, and hand-written
// sequences for backpressure and reset during a rotation search.
module tb_dp_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  cond = '0;
    logic [3:0]  opcode = '0;
    logic        s_bit = 1'b0;
    logic [3:0]  rn = '0;
    logic [3:0]  rd = '0;
    logic        imm_mode = 1'b0;
    logic [31:0] imm_value = '0;
    logic [7:0]  shift = '0;
    logic [3:0]  rm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] instruction;
    logic        enc_error;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0]  cond;
        logic [3:0]  opcode;
        logic        s;
        logic [3:0]  rn;
        logic [3:0]  rd;
        logic        imm_mode;
        logic [31:0] imm;
        logic [7:0]  shift;
        logic [3:0]  rm;
        logic [31:0] exp_instr;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    vec_t tbl[10];

    dp_instr_encoder #(.FORCE_CANON(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .cond        (cond),
        .opcode      (opcode),
        .s_bit       (s_bit),
        .rn          (rn),
        .rd          (rd),
        .imm_mode    (imm_mode),
        .imm_value   (imm_value),
        .shift       (shift),
        .rm          (rm),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .instruction (instruction),
        .enc_error   (enc_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] c, input logic [3:0] op, input logic s,
                                input logic [3:0] n, input logic [3:0] d, input logic im,
                                input logic [31:0] iv, input logic [7:0] sh, input logic [3:0] m,
                                input logic [31:0] ei, input logic ee, input int el);
        vec_t v;
        v.cond = c; v.opcode = op; v.s = s; v.rn = n; v.rd = d; v.imm_mode = im;
        v.imm = iv; v.shift = sh; v.rm = m; v.exp_instr = ei; v.exp_err = ee; v.exp_lat = el;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        cond = v.cond; opcode = v.opcode; s_bit = v.s; rn = v.rn; rd = v.rd;
        imm_mode = v.imm_mode; imm_value = v.imm; shift = v.shift; rm = v.rm;
    endtask

    // Apply one field set, push its expectation, wait for the output and retire it.
    task automatic run_vec(input vec_t v, input string tag);
        exp_t e;
        int   lat;
        @(negedge clk);
        chk({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
        drive(v);
        in_valid = 1'b1;
        e.instr = v.exp_instr; e.err = v.exp_err; e.lat = v.exp_lat;
        sb_q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        drive(mk(4'hF, 4'hF, 1'b1, 4'hF, 4'hF, 1'b1, 32'hFFFF_FFFF, 8'hFF, 4'hF, '0, 1'b0, 0));
        chk({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: out_valid never rose within %0d cycles", tag, lat);
            void'(sb_q.pop_front());
            return;
        end
        e = sb_q.pop_front();
        chk({tag, "_instr"}, instruction, e.instr);
        chk({tag, "_err"}, 32'(enc_error), 32'(e.err));
        chk({tag, "_latency"}, 32'(lat), 32'(e.lat));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_out_valid_after"}, 32'(out_valid), 32'd0);
        chk({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int   quiet_bad;
        vec_t bp;

        // cond opc  S  Rn   Rd  I   imm            shift rm   expected        err lat
        tbl[0] = mk(4'hE, 4'h2, 1, 4'h3, 4'h4, 0, 32'h0,          8'h00, 4'h5, 32'hE053_4005, 0, 0);
        tbl[1] = mk(4'hE, 4'h4, 0, 4'h1, 4'h2, 1, 32'hFF00_0000,  8'h00, 4'h0, 32'hE281_24FF, 0, 5);
        tbl[2] = mk(4'hE, 4'hD, 0, 4'h5, 4'h3, 1, 32'h0000_03FC,  8'h00, 4'h0, 32'hE3A0_3FFF, 0, 16);
        tbl[3] = mk(4'hE, 4'h4, 0, 4'h1, 4'h2, 1, 32'h0000_0101,  8'h00, 4'h0, 32'h0000_0000, 1, 16);
        tbl[4] = mk(4'hE, 4'hA, 0, 4'h1, 4'h7, 0, 32'h0,          8'h00, 4'h2, 32'hE151_0002, 0, 0);
        tbl[5] = mk(4'h0, 4'h0, 1, 4'h2, 4'h2, 1, 32'h0,          8'h00, 4'h0, 32'h0212_2000, 0, 1);
        tbl[6] = mk(4'h1, 4'hC, 0, 4'h6, 4'h7, 0, 32'h0,          8'h8C, 4'h9, 32'h1186_78C9, 0, 0);
        tbl[7] = mk(4'hE, 4'hF, 1, 4'h4, 4'h8, 1, 32'h0000_00AB,  8'h00, 4'h0, 32'hE3F0_80AB, 0, 1);
        tbl[8] = mk(4'hA, 4'h8, 0, 4'h3, 4'h5, 1, 32'h00AB_0000,  8'h00, 4'h0, 32'hA313_08AB, 0, 9);
        tbl[9] = mk(4'hE, 4'h4, 0, 4'h0, 4'h0, 1, 32'h0000_03F0,  8'h00, 4'h0, 32'hE280_0E3F, 0, 15);

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_instruction", instruction, 32'd0);
        chk("rst_enc_error", 32'(enc_error), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_vec(tbl[i], $sformatf("vec%0d", i));
        end

        // Backpressure: output held, in_valid pulses ignored while busy
        bp = mk(4'hE, 4'h3, 0, 4'h1, 4'h2, 0, 32'h0, 8'h00, 4'h3, 32'hE061_2003, 0, 0);
        @(negedge clk);
        drive(bp);
        in_valid = 1'b1;
        @(negedge clk);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_instr", instruction, bp.exp_instr);
        for (int k = 0; k < 3; k++) begin
            drive(tbl[1]);
            in_valid = 1'b1;
            @(negedge clk);
            chk($sformatf("bp_hold%0d_instr", k), instruction, bp.exp_instr);
            chk($sformatf("bp_hold%0d_valid", k), 32'(out_valid), 32'd1);
            chk($sformatf("bp_hold%0d_in_ready", k), 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        chk("bp_no_extra_output", 32'(out_valid), 32'd0);

        // Reset during the search at rotation 6
        drive(tbl[3]);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("mid_search_busy", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_instruction", instruction, 32'd0);
        chk("mid_rst_enc_error", 32'(enc_error), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        quiet_bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) quiet_bad++;
        end
        chk("post_rst_no_stale_output", 32'(quiet_bad), 32'd0);
        run_vec(tbl[0], "post_rst_vec");

        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dp_instr_encoder.md
Name: dp_instr_encoder

Overview:
Builds 32-bit ARM7TDMI data-processing instruction words from separate fields. It is the encoding counterpart to the ALU-side data-processing decoder, and it feeds instruction words to that decoder.
In immediate mode it searches the 16 legal rotations, one per cycle, for an 8-bit immediate plus 4-bit rotate encoding of a 32-bit constant.
Input and output both use valid/ready handshakes. The block holds one instruction in flight.

Parameters:
FORCE_CANON, 1, when 1: compare opcodes (1000-1011) force S=1 and Rd=0; MOV/MVN (1101, 1111) force Rn=0.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  field set valid
in_ready  output  1  encoder can accept a field set
cond  input  4  condition field, bits [31:28]
opcode  input  4  ALU opcode, bits [24:21]
s_bit  input  1  set-flags bit, bit [20]
rn  input  4  first operand register, bits [19:16]
rd  input  4  destination register, bits [15:12]
imm_mode  input  1  1 = immediate operand (I=1), 0 = register operand
imm_value  input  32  constant to encode (imm_mode=1)
shift  input  8  shift field, bits [11:4] (imm_mode=0)
rm  input  4  second operand register, bits [3:0] (imm_mode=0)
out_valid  output  1  instruction valid
out_ready  input  1  consumer accepts instruction
instruction  output  32  encoded word
enc_error  output  1  constant not encodable; qualified by out_valid

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - in_ready=1, out_valid=0, instruction=0, enc_error=0.
  - Rotation counter = 0; all captured fields cleared.
  - Reset asserted mid-SEARCH or mid-OUT abandons the operation; no output is produced for it.
- States: IDLE, SEARCH, OUT.
- IDLE:
  - in_ready=1.
  - Accept occurs when in_valid=1 at a rising edge. All fields are registered at that edge.
  - imm_mode=0: next state OUT.
    - instruction = {cond, 2'b00, 1'b0, opcode, S, Rn, Rd, shift, rm}.
    - out_valid is high in the cycle after the accept edge.
  - imm_mode=1: next state SEARCH with rotation counter r=0.
- SEARCH:
  - in_ready=0.
  - Each cycle, test r: v = imm_value rotated left by 2r (32-bit rotate). Hit when v[31:8]==0.
  - Hit: next state OUT.
    - instruction = {cond, 2'b00, 1'b1, opcode, S, Rn, Rd, r[3:0], v[7:0]}.
    - enc_error=0.
  - Miss with r<15: r <= r+1.
  - Miss with r==15: next state OUT, instruction=0, enc_error=1.
  - The lowest matching r always wins.
  - Latency: first hit at rotation k means k+1 SEARCH cycles; the error case takes 16.
- OUT:
  - out_valid=1, in_ready=0.
  - instruction and enc_error stay stable until out_valid and out_ready are both high at a rising edge.
  - After that edge: IDLE, out_valid=0, r=0.
  - Accepting a new field set in the same cycle as the output handshake is not allowed. Minimum spacing between accepts is 2 cycles.
- Field canonicalisation (FORCE_CANON=1):
  - Opcodes 1000-1011: S=1 and Rd=0000, whatever the inputs.
  - Opcodes 1101 and 1111: Rn=0000.
  - Applied identically in both modes.
- imm_value=0: hits at r=0, giving operand2 = 0x000.
- Input fields that change while in_ready=0 are ignored.

Test Plan:
1. Register mode: cond=E, opcode=0010 (SUB), s_bit=1, rn=3, rd=4, shift=0, rm=5 -> one cycle after accept: out_valid=1, instruction=0xE0534005, enc_error=0.
2. Immediate mode: cond=E, opcode=0100 (ADD), s_bit=0, rn=1, rd=2, imm_value=0xFF000000 -> hit at r=4 after 5 SEARCH cycles; instruction=0xE28124FF.
3. Worst-case and error:
   - imm_value=0x000003FC -> r=15 after 16 SEARCH cycles; operand2=0xFFF.
   - imm_value=0x00000101 -> 16 SEARCH cycles, then out_valid=1, enc_error=1, instruction=0.
4. Canonicalisation: cond=E, opcode=1010 (CMP), s_bit=0, rd=7, rn=1, register mode, rm=2, shift=0 -> instruction=0xE1510002.
5. Backpressure: hold out_ready=0 for 3 cycles in OUT -> instruction stable, in_ready=0, in_valid pulses ignored. Release -> IDLE next cycle, in_ready=1.
6. Reset mid-SEARCH: assert rst_n=0 at r=6 with imm_value=0x101 -> immediately out_valid=0, in_ready=1, instruction=0. After release, no stale output; a following register-mode encode is correct.
